// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard unit for a 5-stage in-order pipeline.
// Tracks the instructions in EX/MEM/WB in a small scoreboard.
// Generates stall, flush and forwarding controls from that scoreboard.
// Waits on data memory for loads and flags loads that time out.
// Optional feature macro: PIPELINE_CTRL_FORWARD_EN.
//   Defined:   operands are forwarded from MEM/WB. Only load-use hazards stall.
//   Undefined: there is no forwarding. Any RAW hazard stalls until the producer retires.
module pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      regwrite_d,
  input  logic                      load_d,
  input  logic                      valid_d,
  input  logic                      pcsrc_e,
  input  logic                      mem_ready,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      stall_all,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      regwrite;
    logic                      load;
  } sb_t;

  sb_t                       r_ex, r_mem, r_wb;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rs1, r_ex_rs2;
  state_t                    r_state, w_state, w_state_nxt;
  logic [TW-1:0]             r_to_cnt;
  logic                      w_mem_stall;
  logic                      w_hz;
  logic                      w_unused;

  // A real producer of register r. x0 is never a producer.
  function automatic logic f_writes(input sb_t e, input logic [REG_ADDR_WIDTH-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

  // The decode instruction reads a register written by entry e.
  function automatic logic f_dec_hit(input sb_t e, input logic v,
                                     input logic [REG_ADDR_WIDTH-1:0] a,
                                     input logic [REG_ADDR_WIDTH-1:0] b);
    return v && (f_writes(e, a) || f_writes(e, b));
  endfunction

  // The WB load bit is kept for completeness. The EX sources only drive forwarding.
  assign w_unused = ^{r_wb.load, r_ex.load, r_ex_rs1, r_ex_rs2};

  // The memory wait is decided by this cycle's mem_ready, so it overrides the registered state.
  assign w_mem_stall = r_mem.valid & r_mem.load & ~mem_ready;

  // Effective current state: MEM_WAIT while a load in MEM is outstanding.
  always_comb begin
    w_state = ST_RUN;
    if (w_mem_stall)                 w_state = ST_MEM_WAIT;
    else if (r_state == ST_LOAD_USE) w_state = ST_LOAD_USE;
  end

  // Hazard detection against the scoreboard.
  always_comb begin
    w_hz = 1'b0;
    if (w_state == ST_RUN) begin
`ifdef PIPELINE_CTRL_FORWARD_EN
      w_hz = r_ex.load && f_dec_hit(r_ex, valid_d, rs1_d, rs2_d);
`else
      w_hz = f_dec_hit(r_ex,  valid_d, rs1_d, rs2_d) ||
             f_dec_hit(r_mem, valid_d, rs1_d, rs2_d) ||
             f_dec_hit(r_wb,  valid_d, rs1_d, rs2_d);
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state. LOAD_USE is a single-cycle shadow after a load-use stall.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_mem_stall) w_state_nxt = ST_MEM_WAIT;
`ifdef PIPELINE_CTRL_FORWARD_EN
    else if (w_hz && !pcsrc_e) w_state_nxt = ST_LOAD_USE;
`endif
  end

  // FSM outputs. A branch flush beats a stall, and nothing but stall_all is driven in MEM_WAIT.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_all = 1'b0;
    if (w_state == ST_MEM_WAIT) begin
      stall_all = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (w_hz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Operand forwarding. The younger MEM result wins over WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef PIPELINE_CTRL_FORWARD_EN
    if (f_writes(r_mem, r_ex_rs1))     fwd_a = 2'b10;
    else if (f_writes(r_wb, r_ex_rs1)) fwd_a = 2'b01;
    if (f_writes(r_mem, r_ex_rs2))     fwd_b = 2'b10;
    else if (f_writes(r_wb, r_ex_rs2)) fwd_b = 2'b01;
`endif
  end

  // The scoreboard shifts with the pipeline. A flushed decode enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
    end else if (!stall_all) begin
      if (flush_e) begin
        r_ex     <= '0;
        r_ex_rs1 <= '0;
        r_ex_rs2 <= '0;
      end else begin
        r_ex     <= {valid_d, rd_d, regwrite_d, load_d};
        r_ex_rs1 <= rs1_d;
        r_ex_rs2 <= rs2_d;
      end
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // Load timeout. The counter saturates, and the error sticks while the wait goes on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (w_mem_stall) begin
      if (r_to_cnt != TW'(MEM_TIMEOUT))     r_to_cnt <= r_to_cnt + TW'(1);
      if (r_to_cnt == TW'(MEM_TIMEOUT - 1)) mem_err  <= 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if ((stall_d | stall_all) && (stall_count != '1))
      stall_count <= stall_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios, then randomized traffic.
// A queue-based reference model predicts every output.
// Each cycle the stimulus pushes its expectation, and a negedge monitor pops and compares it.
module tb_pipeline_ctrl;
  localparam int RW = 5;
  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1_d, rs2_d, rd_d;
  logic          regwrite_d, load_d, valid_d, pcsrc_e, mem_ready;
  logic          stall_f, stall_d, flush_d, flush_e, stall_all, mem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  pipeline_ctrl #(.REG_ADDR_WIDTH(RW), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .valid_d(valid_d),
    .pcsrc_e(pcsrc_e), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_all(stall_all), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int rd; bit rw; bit ld; int rs1; int rs2;} ins_t;
  typedef struct {bit sf, sd, fd, fe, sa; int fa, fb; bit err; int cnt;} exp_t;

  // The model keeps the instructions ahead of decode. Element 0 is in execute, 1 in memory, 2 in writeback.
  ins_t hist[$];
  exp_t expq[$];
  int   waitcyc, m_cnt;
  bit   m_err, lu_prev;
  int   checks = 0, failures = 0;

  function automatic bit writes(input ins_t p, input int r);
    return p.v && p.rw && (p.rd != 0) && (p.rd == r);
  endfunction

  function automatic bit reads(input ins_t p, input bit v, input int a, input int b);
    return v && (writes(p, a) || writes(p, b));
  endfunction

  task automatic model_reset();
    ins_t bub;
    bub = '{0, 0, 0, 0, 0, 0};
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back(bub);
    waitcyc = 0; m_cnt = 0; m_err = 0; lu_prev = 0;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs. Predict this cycle's outputs, then advance the model past the next edge.
  task automatic cyc(input int a, input int b, input int d, input bit w, input bit l,
                     input bit v, input bit pc, input bit mr, input bit r);
    exp_t e;
    ins_t ex, mm, wb, bub, n;
    bit busy, hz;
    @(posedge clk); #1;
    rs1_d = RW'(a); rs2_d = RW'(b); rd_d = RW'(d);
    regwrite_d = w; load_d = l; valid_d = v; pcsrc_e = pc; mem_ready = mr; rst = r;
    if (r) begin
      model_reset();
      return;
    end
    bub = '{0, 0, 0, 0, 0, 0};
    ex = hist[0]; mm = hist[1]; wb = hist[2];
    busy = mm.v && mm.ld && !mr;
`ifdef PIPELINE_CTRL_FORWARD_EN
    hz = !lu_prev && ex.ld && reads(ex, v, a, b);
    e.fa = writes(mm, ex.rs1) ? 2 : writes(wb, ex.rs1) ? 1 : 0;
    e.fb = writes(mm, ex.rs2) ? 2 : writes(wb, ex.rs2) ? 1 : 0;
`else
    hz = reads(ex, v, a, b) || reads(mm, v, a, b) || reads(wb, v, a, b);
    e.fa = 0; e.fb = 0;
`endif
    e.sa = busy;
    e.fd = !busy && pc;
    e.fe = !busy && (pc || hz);
    e.sf = !busy && !pc && hz;
    e.sd = e.sf;
    e.err = m_err;
    e.cnt = m_cnt;
    expq.push_back(e);
    if (busy) begin
      waitcyc++;
      if (waitcyc >= TO) m_err = 1;
    end else begin
      waitcyc = 0;
      n = e.fe ? bub : '{v, d, w, l, a, b};
      hist.push_front(n);
      void'(hist.pop_back());
    end
    if ((e.sd || e.sa) && m_cnt < (1 << CW) - 1) m_cnt++;
    lu_prev = !busy && !pc && hz;
  endtask

  task automatic nop(input bit mr);
    cyc(0, 0, 0, 0, 0, 0, 0, mr, 0);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall_f",     int'(stall_f),     int'(e.sf));
      chk("stall_d",     int'(stall_d),     int'(e.sd));
      chk("flush_d",     int'(flush_d),     int'(e.fd));
      chk("flush_e",     int'(flush_e),     int'(e.fe));
      chk("stall_all",   int'(stall_all),   int'(e.sa));
      chk("fwd_a",       int'(fwd_a),       e.fa);
      chk("fwd_b",       int'(fwd_b),       e.fb);
      chk("mem_err",     int'(mem_err),     int'(e.err));
      chk("stall_count", int'(stall_count), e.cnt);
    end
  end

  initial begin
    int burst;
    bit mr;
    rst = 1'b1; rs1_d = '0; rs2_d = '0; rd_d = '0;
    regwrite_d = 0; load_d = 0; valid_d = 0; pcsrc_e = 0; mem_ready = 1;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    // First cycle out of reset, with a decode that would hit anything.
    cyc(3, 5, 7, 1, 1, 1, 0, 1, 0);

    // add x3, then a reader of x3 held in decode while stalled.
    cyc(0, 0, 3, 1, 0, 1, 0, 1, 0);
    repeat (5) cyc(3, 3, 4, 1, 0, 1, 0, 1, 0);

    // lw x5, then add x6,x5,x1 with memory ready.
    cyc(0, 0, 5, 1, 1, 1, 0, 1, 0);
    repeat (5) cyc(5, 1, 6, 1, 0, 1, 0, 1, 0);

    // lw x5 in memory with mem_ready low for three cycles.
    cyc(0, 0, 5, 1, 1, 1, 0, 1, 0);
    nop(1); nop(0); nop(0); nop(0); nop(1); nop(1); nop(1);

    // Timeout: mem_ready low for six cycles. The error sticks until reset.
    cyc(0, 0, 5, 1, 1, 1, 0, 1, 0);
    nop(1);
    repeat (6) nop(0);
    repeat (4) nop(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(1);

    // A hazard and a branch in the same cycle.
    cyc(0, 0, 3, 1, 1, 1, 0, 1, 0);
    cyc(3, 0, 4, 1, 0, 1, 1, 1, 0);
    nop(1); nop(1);

    // A branch during a memory wait is ignored.
    cyc(0, 0, 5, 1, 1, 1, 0, 1, 0);
    nop(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    nop(1); nop(1);

    // Reset in the middle of a memory wait.
    cyc(0, 0, 5, 1, 1, 1, 0, 1, 0);
    nop(1); nop(0); nop(0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(0); nop(0);

    // Random traffic without reset, long enough to saturate stall_count, then with sparse resets.
    burst = 0;
    for (int i = 0; i < 2400; i++) begin
      if (burst > 0) begin
        mr = 0; burst--;
      end else if ($urandom_range(0, 19) == 0) begin
        mr = 0; burst = $urandom_range(1, 7);
      end else begin
        mr = ($urandom_range(0, 7) != 0);
      end
      cyc($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), mr,
          (i > 1600) && ($urandom_range(0, 99) == 0));
    end

    nop(1);
    @(posedge clk); @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register-index width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of cycles a load may wait on mem_ready before mem_err is raised.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning stall_count width.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rs1_d, rs2_d  input  REG_ADDR_WIDTH each  source registers of the instruction in decode.
REQ-007 rd_d  input  REG_ADDR_WIDTH  destination register of the instruction in decode.
REQ-008 regwrite_d, load_d, valid_d  input  1 each  decode writes rd; decode is a load; decode holds a real instruction.
REQ-009 pcsrc_e  input  1  taken branch or jump resolved in execute.
REQ-010 mem_ready  input  1  data memory has completed the current load.
REQ-011 stall_f, stall_d  output  1 each  hold the PC and the IF/ID register.
REQ-012 flush_d, flush_e  output  1 each  bubble the IF/ID and ID/EX registers.
REQ-013 stall_all  output  1  freeze every pipeline register.
REQ-014 fwd_a, fwd_b  output  2 each  execute operand select: 00 register file, 10 from EX/MEM, 01 from MEM/WB.
REQ-015 mem_err  output  1  sticky load-timeout flag.
REQ-016 stall_count  output  CNT_WIDTH  count of cycles with stall_d or stall_all high.

Function
REQ-017 SHALL keep a scoreboard of three entries (ex_q, mem_q, wb_q). Each entry holds {valid, rd, regwrite, load}; ex_q also holds rs1 and rs2.
REQ-018 Scoreboard advance: on each edge with stall_all=0, ex_q<=decode fields, mem_q<=ex_q, and wb_q<=mem_q. ex_q loads a bubble (valid=0) instead when flush_e=1.
REQ-019 A producer entry counts only if valid=1, regwrite=1 and rd!=0. Register x0 never causes a hazard or a forward.
REQ-020 The FSM SHALL have three states: RUN, LOAD_USE and MEM_WAIT. The reset state is RUN.
REQ-021 Load-use hazard: in RUN, decode reads a register (valid_d=1) that matches ex_q.rd, and ex_q is a load producer. The block drives stall_f=stall_d=flush_e=1 in that cycle and moves to LOAD_USE.
REQ-022 LOAD_USE SHALL last exactly one cycle. It drives no stall and returns to RUN, or enters MEM_WAIT under the REQ-023 condition.
REQ-023 MEM_WAIT entry and exit: the state is MEM_WAIT while mem_q is a valid load and mem_ready=0. In MEM_WAIT, stall_all=1 and all other stall/flush outputs are 0. The FSM returns to RUN on the first cycle with mem_ready=1; the scoreboard advances on that edge.
REQ-024 Timeout: a counter increments each MEM_WAIT cycle and clears on exit. When it reaches MEM_TIMEOUT, mem_err is set and stays 1 until rst. The wait continues.
REQ-025 Branch flush: pcsrc_e=1 drives flush_d=flush_e=1 in the same cycle, combinationally. This has priority over a load-use stall, which drives stall_f=stall_d=0 that cycle. pcsrc_e is ignored while stall_all=1.
REQ-026 Forwarding priority: fwd_a/fwd_b select 10 when ex_q.rs1/ex_q.rs2 matches a producer in mem_q. Otherwise they select 01 on a match in wb_q, else 00. mem_q has priority when both match.
REQ-027 Stall-flush same cycle: when a load-use stall and pcsrc_e coincide, the stalled decode instruction is discarded (flush_d=1).
REQ-028 stall_count SHALL increment on every cycle with stall_d|stall_all=1, and saturate at all-ones.
REQ-029 Hazard outputs are combinational from the state, the scoreboard and the inputs. mem_err and stall_count are registered.

Reset
REQ-030 On rst=1 at an edge, the block SHALL clear all scoreboard valid bits and set the FSM to RUN. The timeout counter, mem_err and stall_count are cleared to 0.
REQ-031 On the cycle after reset, stall_f, stall_d, flush_d, flush_e, stall_all, fwd_a and fwd_b SHALL all be 0 when pcsrc_e=0, whatever the decode inputs.
REQ-032 Reset during MEM_WAIT SHALL abandon the wait immediately. No stall is carried over.

Configuration
REQ-033 Macro PIPELINE_CTRL_FORWARD_EN present: behaviour is exactly as in REQ-021 to REQ-026.
REQ-034 Macro absent: fwd_a=fwd_b=00 at all times. Any decode source matching a producer in ex_q, mem_q or wb_q drives stall_f=stall_d=flush_e=1 while the FSM stays in RUN, and the stall repeats until no match remains. LOAD_USE is unused.

Verification
REQ-035 Scenario: lw x5 then add x6,x5,x1 back-to-back, mem_ready=1 -> one cycle of stall_f=stall_d=flush_e=1; on the next cycle fwd_a=01 for the add.
REQ-036 Scenario: add x3 then sub x4,x3,x3 -> no stall; fwd_a=fwd_b=10 while sub is in execute.
REQ-037 Scenario: lw in memory with mem_ready low for 3 cycles -> stall_all=1 for exactly 3 cycles; stall_count=3; mem_err=0.
REQ-038 Scenario: MEM_TIMEOUT=4 and mem_ready held low for 6 cycles -> mem_err rises after the 4th wait cycle and stays 1 until rst.
REQ-039 Scenario: load-use hazard and pcsrc_e=1 in the same cycle -> flush_d=flush_e=1 and stall_f=stall_d=0.
REQ-040 Scenario: build without PIPELINE_CTRL_FORWARD_EN, add x3 followed by use of x3 -> stall for 3 cycles; fwd outputs remain 00.
